// File: rtl/rover_pkg.sv
// Shared types and encodings for the rover drive controller.
// The soft-start option is selected with the ROVER_SOFT_START_EN macro in rover_drive_fsm.
package rover_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    BLOCKED = 3'd2,
    TURN    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MOT_FWD  = 2'b10;
  localparam logic [1:0] MOT_REV  = 2'b01;
  localparam logic [1:0] MOT_STOP = 2'b00;

  localparam logic [1:0] TP_NONE  = 2'd0;
  localparam logic [1:0] TP_LEFT  = 2'd1;
  localparam logic [1:0] TP_RIGHT = 2'd2;
  localparam logic [1:0] TP_UTURN = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit debouncer: the output follows the raw input only after the two
// have disagreed for DEB_CYCLES consecutive cycles; any agreement restarts the count.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (raw == deb) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      deb <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rover_drive_fsm.sv
// Rover drive controller: H-bridge direction/PWM control, timed turns and obstacle halt.
// Define ROVER_SOFT_START_EN to ramp the effective duty up after each entry to DRIVE.
//
// state   | meaning
// IDLE    | motors stopped, waiting for enable_motor
// DRIVE   | both sides forward, PWM on both enables
// BLOCKED | obstacle seen, motors stopped
// TURN    | timed pivot at full power, busy high
// DONE    | one-cycle completion pulse, motors stopped
module rover_drive_fsm
  import rover_pkg::*;
#(
  parameter int N_SENS      = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int TURN_CYCLES = 100,
  parameter int TURN_W      = 16,
  parameter int PWM_W       = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable_motor,
  input  logic [1:0]        turn_procedure,
  input  logic [N_SENS-1:0] RF_sensor,
  input  logic [PWM_W-1:0]  duty,
  output logic [1:0]        motorL,
  output logic [1:0]        motorR,
  output logic [1:0]        enableAB,
  output logic              done_turning,
  output logic [N_SENS-1:0] obstacle,
  output logic              busy
);

  localparam logic [TURN_W-1:0] TURN_LOAD  = TURN_W'(TURN_CYCLES - 1);
  localparam logic [TURN_W-1:0] UTURN_LOAD = TURN_W'(2 * TURN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [1:0]         tp_prev;
  logic [1:0]         turn_dir_q, turn_dir_d;
  logic [TURN_W-1:0]  turn_cnt;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   duty_eff;
  logic               pwm, blk, treq;
  logic [1:0]         ml_d, mr_d, en_d;
  logic               busy_d, done_d;

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLK   (CLK),
      .RST_N (RST_N),
      .raw   (RF_sensor[i]),
      .deb   (obstacle[i])
    );
  end

  assign blk  = |obstacle;
  assign treq = (turn_procedure != tp_prev) && (turn_procedure != TP_NONE);
  assign pwm  = (pwm_cnt < duty_eff);

`ifdef ROVER_SOFT_START_EN
  // Ramp one step per PWM period; a lowered duty is followed at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      duty_eff <= '0;
    end else if (state_q != DRIVE) begin
      duty_eff <= '0;
    end else if (duty < duty_eff) begin
      duty_eff <= duty;
    end else if ((pwm_cnt == '1) && (duty_eff != duty)) begin
      duty_eff <= duty_eff + PWM_W'(1);
    end
  end
`else
  assign duty_eff = duty;
`endif

  always_comb begin
    state_d    = state_q;
    ml_d       = MOT_STOP;
    mr_d       = MOT_STOP;
    en_d       = 2'b00;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    // The turn direction is latched on entry so later tp changes cannot steer it.
    turn_dir_d = (state_q == TURN) ? turn_dir_q : turn_procedure;

    if (!enable_motor) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = treq ? TURN : (blk ? BLOCKED : DRIVE);
        DRIVE:   state_d = treq ? TURN : (blk ? BLOCKED : DRIVE);
        BLOCKED: state_d = treq ? TURN : (blk ? BLOCKED : DRIVE);
        TURN:    state_d = (turn_cnt == '0) ? DONE : TURN;
        DONE:    state_d = blk ? BLOCKED : DRIVE;
        default: state_d = IDLE;
      endcase
    end

    unique case (state_d)
      DRIVE: begin
        ml_d = MOT_FWD;
        mr_d = MOT_FWD;
        en_d = {pwm, pwm};
      end
      TURN: begin
        en_d   = 2'b11;
        busy_d = 1'b1;
        if (turn_dir_d == TP_RIGHT) begin
          ml_d = MOT_FWD;
          mr_d = MOT_REV;
        end else begin
          ml_d = MOT_REV;
          mr_d = MOT_FWD;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      tp_prev      <= TP_NONE;
      turn_dir_q   <= TP_NONE;
      turn_cnt     <= '0;
      pwm_cnt      <= '0;
      motorL       <= MOT_STOP;
      motorR       <= MOT_STOP;
      enableAB     <= 2'b00;
      busy         <= 1'b0;
      done_turning <= 1'b0;
    end else begin
      state_q      <= state_d;
      tp_prev      <= turn_procedure;
      turn_dir_q   <= turn_dir_d;
      pwm_cnt      <= pwm_cnt + PWM_W'(1);
      motorL       <= ml_d;
      motorR       <= mr_d;
      enableAB     <= en_d;
      busy         <= busy_d;
      done_turning <= done_d;
      if ((state_d == TURN) && (state_q != TURN)) begin
        turn_cnt <= (turn_procedure == TP_UTURN) ? UTURN_LOAD : TURN_LOAD;
      end else if ((state_q == TURN) && (turn_cnt != '0)) begin
        turn_cnt <= turn_cnt - TURN_W'(1);
      end
    end
  end

endmodule
